// File: rtl/finish_dst_router.sv
// finish_dst_router
//   Downstream stage of the 4-input finish-message arbiter. Each arbitrated
//   message (src, dst, manager_xact_id) is buffered in a DEPTH-entry circular
//   FIFO together with the arbiter's grant index. The head entry is steered
//   to the output port selected by its dst field.
//
// Ports
//   clk, reset (sync, active-low)
//   io_enq_*          : enqueue side; io_enq_ready feeds the arbiter's io_out_ready
//   io_out_k_*        : per-destination outputs (k = 0..3); bits broadcast to all k
//   io_head_chosen    : stored grant index of the head entry (debug/trace)
//   io_count          : current occupancy, 0..DEPTH
module finish_dst_router #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             io_enq_ready,
  input  logic             io_enq_valid,
  input  logic [1:0]       io_enq_bits_header_src,
  input  logic [1:0]       io_enq_bits_header_dst,
  input  logic [1:0]       io_enq_bits_payload_manager_xact_id,
  input  logic [1:0]       io_enq_chosen,
  input  logic             io_out_0_ready,
  output logic             io_out_0_valid,
  output logic [1:0]       io_out_0_bits_header_src,
  output logic [1:0]       io_out_0_bits_header_dst,
  output logic [1:0]       io_out_0_bits_payload_manager_xact_id,
  input  logic             io_out_1_ready,
  output logic             io_out_1_valid,
  output logic [1:0]       io_out_1_bits_header_src,
  output logic [1:0]       io_out_1_bits_header_dst,
  output logic [1:0]       io_out_1_bits_payload_manager_xact_id,
  input  logic             io_out_2_ready,
  output logic             io_out_2_valid,
  output logic [1:0]       io_out_2_bits_header_src,
  output logic [1:0]       io_out_2_bits_header_dst,
  output logic [1:0]       io_out_2_bits_payload_manager_xact_id,
  input  logic             io_out_3_ready,
  output logic             io_out_3_valid,
  output logic [1:0]       io_out_3_bits_header_src,
  output logic [1:0]       io_out_3_bits_header_dst,
  output logic [1:0]       io_out_3_bits_payload_manager_xact_id,
  output logic [1:0]       io_head_chosen,
  output logic [CNT_W-1:0] io_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Entry layout: {chosen, xact_id, dst, src}
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] cnt;

  logic       empty;
  logic       enq_fire;
  logic       deq_fire;
  logic [7:0] head;
  logic [1:0] head_dst;
  logic [3:0] out_vld;
  logic [3:0] out_rdy;

  // Explicit wrap so a non-power-of-2 DEPTH never aliases.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Enqueue / dequeue handshakes
  assign empty        = (cnt == '0);
  // Full blocks enqueue even when a dequeue fires this cycle (no pipe-through).
  assign io_enq_ready = (cnt != CNT_FULL);
  assign enq_fire     = io_enq_valid & io_enq_ready;

  assign head     = mem[rptr];
  assign head_dst = head[3:2];
  assign out_vld  = empty ? 4'b0000 : (4'b0001 << head_dst);
  assign out_rdy  = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};
  // Ready on a non-addressed port is masked by out_vld.
  assign deq_fire = |(out_vld & out_rdy);

  // Storage register stage: memory carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (enq_fire)
      mem[wptr] <= {io_enq_chosen, io_enq_bits_payload_manager_xact_id,
                    io_enq_bits_header_dst, io_enq_bits_header_src};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (enq_fire) wptr <= ptr_inc(wptr);
      if (deq_fire) rptr <= ptr_inc(rptr);
      case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Output steering from the head entry
  assign io_out_0_valid = out_vld[0];
  assign io_out_1_valid = out_vld[1];
  assign io_out_2_valid = out_vld[2];
  assign io_out_3_valid = out_vld[3];

  assign io_out_0_bits_header_src = head[1:0];
  assign io_out_1_bits_header_src = head[1:0];
  assign io_out_2_bits_header_src = head[1:0];
  assign io_out_3_bits_header_src = head[1:0];

  assign io_out_0_bits_header_dst = head_dst;
  assign io_out_1_bits_header_dst = head_dst;
  assign io_out_2_bits_header_dst = head_dst;
  assign io_out_3_bits_header_dst = head_dst;

  assign io_out_0_bits_payload_manager_xact_id = head[5:4];
  assign io_out_1_bits_payload_manager_xact_id = head[5:4];
  assign io_out_2_bits_payload_manager_xact_id = head[5:4];
  assign io_out_3_bits_payload_manager_xact_id = head[5:4];

  assign io_head_chosen = head[7:6];
  assign io_count       = cnt;

endmodule

// File: tb/tb_finish_dst_router.sv
module tb_finish_dst_router;

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
    logic [1:0] xact;
    logic [1:0] ch;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_del3 = 0;

  exp_t q2[$];
  exp_t q3[$];

  // Instance A: DEPTH=2
  logic       ev2 = 1'b0;
  logic [1:0] es2 = '0, ed2 = '0, ex2 = '0, ec2 = '0;
  logic [3:0] rdy2 = '0;
  logic       erdy2;
  logic [3:0] vld2;
  logic [1:0] src2 [4];
  logic [1:0] dst2 [4];
  logic [1:0] xid2 [4];
  logic [1:0] hch2;
  logic [3:0] cnt2;

  // Instance B: DEPTH=3
  logic       ev3 = 1'b0;
  logic [1:0] es3 = '0, ed3 = '0, ex3 = '0, ec3 = '0;
  logic [3:0] rdy3 = '0;
  logic       erdy3;
  logic [3:0] vld3;
  logic [1:0] src3 [4];
  logic [1:0] dst3 [4];
  logic [1:0] xid3 [4];
  logic [1:0] hch3;
  logic [3:0] cnt3;

  finish_dst_router #(.DEPTH(2), .CNT_W(4)) u_d2 (
    .clk(clk), .reset(reset),
    .io_enq_ready(erdy2), .io_enq_valid(ev2),
    .io_enq_bits_header_src(es2), .io_enq_bits_header_dst(ed2),
    .io_enq_bits_payload_manager_xact_id(ex2), .io_enq_chosen(ec2),
    .io_out_0_ready(rdy2[0]), .io_out_0_valid(vld2[0]),
    .io_out_0_bits_header_src(src2[0]), .io_out_0_bits_header_dst(dst2[0]),
    .io_out_0_bits_payload_manager_xact_id(xid2[0]),
    .io_out_1_ready(rdy2[1]), .io_out_1_valid(vld2[1]),
    .io_out_1_bits_header_src(src2[1]), .io_out_1_bits_header_dst(dst2[1]),
    .io_out_1_bits_payload_manager_xact_id(xid2[1]),
    .io_out_2_ready(rdy2[2]), .io_out_2_valid(vld2[2]),
    .io_out_2_bits_header_src(src2[2]), .io_out_2_bits_header_dst(dst2[2]),
    .io_out_2_bits_payload_manager_xact_id(xid2[2]),
    .io_out_3_ready(rdy2[3]), .io_out_3_valid(vld2[3]),
    .io_out_3_bits_header_src(src2[3]), .io_out_3_bits_header_dst(dst2[3]),
    .io_out_3_bits_payload_manager_xact_id(xid2[3]),
    .io_head_chosen(hch2), .io_count(cnt2)
  );

  finish_dst_router #(.DEPTH(3), .CNT_W(4)) u_d3 (
    .clk(clk), .reset(reset),
    .io_enq_ready(erdy3), .io_enq_valid(ev3),
    .io_enq_bits_header_src(es3), .io_enq_bits_header_dst(ed3),
    .io_enq_bits_payload_manager_xact_id(ex3), .io_enq_chosen(ec3),
    .io_out_0_ready(rdy3[0]), .io_out_0_valid(vld3[0]),
    .io_out_0_bits_header_src(src3[0]), .io_out_0_bits_header_dst(dst3[0]),
    .io_out_0_bits_payload_manager_xact_id(xid3[0]),
    .io_out_1_ready(rdy3[1]), .io_out_1_valid(vld3[1]),
    .io_out_1_bits_header_src(src3[1]), .io_out_1_bits_header_dst(dst3[1]),
    .io_out_1_bits_payload_manager_xact_id(xid3[1]),
    .io_out_2_ready(rdy3[2]), .io_out_2_valid(vld3[2]),
    .io_out_2_bits_header_src(src3[2]), .io_out_2_bits_header_dst(dst3[2]),
    .io_out_2_bits_payload_manager_xact_id(xid3[2]),
    .io_out_3_ready(rdy3[3]), .io_out_3_valid(vld3[3]),
    .io_out_3_bits_header_src(src3[3]), .io_out_3_bits_header_dst(dst3[3]),
    .io_out_3_bits_payload_manager_xact_id(xid3[3]),
    .io_head_chosen(hch3), .io_count(cnt3)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one delivered message against the scoreboard head.
  task automatic deliver(input string tag, input exp_t e, input logic [3:0] vld,
                         input logic [1:0] s, input logic [1:0] d,
                         input logic [1:0] x, input logic [1:0] c);
    check({tag, "_onehot"}, int'(vld), 1 << e.dst);
    check({tag, "_src"},    int'(s),   int'(e.src));
    check({tag, "_dst"},    int'(d),   int'(e.dst));
    check({tag, "_xact"},   int'(x),   int'(e.xact));
    check({tag, "_chosen"}, int'(c),   int'(e.ch));
  endtask

  function automatic int first_bit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Monitors: a handshake seen at the falling edge completes at the next rising edge.
  exp_t m2_e;
  int   m2_k;
  always @(negedge clk) begin
    if (reset && |(vld2 & rdy2)) begin
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d2_spurious: got valid=%b with nothing expected", vld2);
      end else begin
        m2_e = q2.pop_front();
        m2_k = first_bit(vld2 & rdy2);
        deliver("d2", m2_e, vld2, src2[m2_k], dst2[m2_k], xid2[m2_k], hch2);
      end
    end
  end

  exp_t m3_e;
  int   m3_k;
  always @(negedge clk) begin
    if (reset && |(vld3 & rdy3)) begin
      if (q3.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d3_spurious: got valid=%b with nothing expected", vld3);
      end else begin
        m3_e = q3.pop_front();
        m3_k = first_bit(vld3 & rdy3);
        n_del3++;
        deliver("d3", m3_e, vld3, src3[m3_k], dst3[m3_k], xid3[m3_k], hch3);
      end
    end
  end

  // One-cycle enqueue into instance A.
  task automatic enq2(input logic [1:0] s, input logic [1:0] d,
                      input logic [1:0] x, input logic [1:0] c);
    exp_t e;
    es2 = s; ed2 = d; ex2 = x; ec2 = c; ev2 = 1'b1;
    check("d2_enq_ready", int'(erdy2), 1);
    e.src = s; e.dst = d; e.xact = x; e.ch = c;
    q2.push_back(e);
    tick();
    ev2 = 1'b0;
  endtask

  initial begin
    exp_t e3;
    int   guard;

    // Reset then idle
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    check("rst_ready", int'(erdy2), 1);
    check("rst_count", int'(cnt2), 0);
    check("rst_valids", int'(vld2), 0);
    check("rst_valids_d3", int'(vld3), 0);
    tick();

    // Single message to dst 2
    rdy2 = 4'b0100;
    enq2(2'd1, 2'd2, 2'd3, 2'd1);
    check("single_count1", int'(cnt2), 1);
    check("single_valids", int'(vld2), 4'b0100);
    tick();
    check("single_count0", int'(cnt2), 0);
    check("single_empty", int'(vld2), 0);
    rdy2 = 4'b0000;

    // Fill to full, dequeue one, ready returns
    enq2(2'd2, 2'd0, 2'd1, 2'd0);
    enq2(2'd3, 2'd3, 2'd2, 2'd3);
    check("full_count", int'(cnt2), 2);
    check("full_ready", int'(erdy2), 0);
    check("full_head0", int'(vld2), 4'b0001);
    rdy2 = 4'b0001;
    check("full_no_pipethru", int'(erdy2), 0);
    tick();
    rdy2 = 4'b0000;
    check("after_deq_count", int'(cnt2), 1);
    check("after_deq_head3", int'(vld2), 4'b1000);
    check("after_deq_ready", int'(erdy2), 1);
    rdy2 = 4'b1000;
    tick();
    rdy2 = 4'b0000;
    check("drain_count", int'(cnt2), 0);

    // Head-of-line blocking
    enq2(2'd0, 2'd1, 2'd2, 2'd2);
    enq2(2'd1, 2'd0, 2'd0, 2'd1);
    rdy2 = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      check("hol_v0_blocked", int'(vld2[0]), 0);
      check("hol_count", int'(cnt2), 2);
      tick();
    end
    rdy2 = 4'b0011;
    tick();
    rdy2 = 4'b0001;
    check("hol_next_head", int'(vld2), 4'b0001);
    tick();
    rdy2 = 4'b0000;
    check("hol_drained", int'(cnt2), 0);

    // Reset mid-operation flushes held entries
    enq2(2'd3, 2'd2, 2'd1, 2'd0);
    enq2(2'd2, 2'd1, 2'd3, 2'd2);
    check("mid_count2", int'(cnt2), 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    q2.delete();
    check("mid_count0", int'(cnt2), 0);
    check("mid_valids0", int'(vld2), 0);
    check("mid_ready", int'(erdy2), 1);
    rdy2 = 4'b1111;
    for (int i = 0; i < 4; i++) tick();
    check("mid_stays_empty", int'(cnt2), 0);
    rdy2 = 4'b0000;

    // Streaming through DEPTH=3: 10 back-to-back messages, pointers wrap 3 times
    rdy3 = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      e3.src  = 2'((i + 1) % 4);
      e3.dst  = 2'(i % 4);
      e3.xact = 2'((i * 3) % 4);
      e3.ch   = 2'((i + 2) % 4);
      es3 = e3.src; ed3 = e3.dst; ex3 = e3.xact; ec3 = e3.ch; ev3 = 1'b1;
      check("stream_enq_ready", int'(erdy3), 1);
      q3.push_back(e3);
      tick();
      check("stream_count_le1", int'(cnt3 <= 4'd1), 1);
    end
    ev3 = 1'b0;
    guard = 0;
    while (q3.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("stream_all_delivered", q3.size(), 0);
    check("stream_delivery_count", n_del3, 10);
    check("stream_final_count", int'(cnt3), 0);
    rdy3 = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/finish_dst_router.md
Name: finish_dst_router

Overview:
- Downstream stage of the 4-input locking round-robin finish-message arbiter.
- Buffers each arbitrated message (header src/dst plus manager_xact_id) in a small FIFO.
- Steers the head entry to one of four per-destination output ports selected by header_dst.
- Decouples the arbiter's io_out_ready from destination backpressure; the arbiter's io_chosen is captured alongside each entry for debug and trace.

Parameters:
- DEPTH, 2, number of FIFO entries; legal range 1..8.
- CNT_W, 4, width of the occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset asserted.
- io_enq_ready  output  1  FIFO can accept; drives the arbiter's io_out_ready.
- io_enq_valid  input  1  from the arbiter's io_out_valid.
- io_enq_bits_header_src  input  2  source id.
- io_enq_bits_header_dst  input  2  destination id; selects the output port.
- io_enq_bits_payload_manager_xact_id  input  2  manager transaction id.
- io_enq_chosen  input  2  arbiter grant index, stored with the entry.
- io_out_k_ready  input  1  destination k accepts (k = 0..3, four ports).
- io_out_k_valid  output  1  head entry valid and addressed to k.
- io_out_k_bits_header_src  output  2  head src, broadcast to all k.
- io_out_k_bits_header_dst  output  2  head dst, broadcast to all k.
- io_out_k_bits_payload_manager_xact_id  output  2  head xact id, broadcast to all k.
- io_head_chosen  output  2  stored grant index of the head entry.
- io_count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- **Storage**
  - Circular buffer of DEPTH entries, 8 bits each: src, dst, xact_id, chosen.
  - Read pointer rptr, write pointer wptr, counter cnt.
  - Both pointers wrap from DEPTH-1 to 0. Non-power-of-2 DEPTH wraps explicitly; there is no modulo aliasing.
- **Reset** (reset==0 at a clock edge): rptr=0, wptr=0, cnt=0. Memory contents are not reset. The same edge gives io_enq_ready=1, all io_out_k_valid=0, io_count=0.
- **Enqueue**
  - io_enq_ready = (cnt != DEPTH). There is no combinational dependence on any io_out_k_ready.
  - enq_fire = io_enq_valid & io_enq_ready.
  - On enq_fire, write mem[wptr] and advance wptr.
- **Dequeue**
  - empty = (cnt == 0). head = mem[rptr].
  - io_out_k_valid = !empty & (head.dst == k). Exactly one port is valid when non-empty.
  - deq_fire = OR over k of (io_out_k_valid & io_out_k_ready).
  - On deq_fire, advance rptr.
- **Count**
  - cnt_next = cnt + enq_fire - deq_fire.
  - Simultaneous enq and deq leaves cnt unchanged and moves both pointers.
- **Latency**: no bypass. An entry enqueued at edge N is presented at the outputs from cycle N+1. Minimum latency is 1 cycle; throughput is 1 message per cycle when DEPTH >= 2.
- **Full**: while cnt==DEPTH, io_enq_ready=0 even if a dequeue fires that cycle. There is no pipe-through, so a full queue accepts again the cycle after a dequeue.
- **Empty**: all io_out_k_valid=0 and the bits outputs hold don't-care values. Asserting io_out_k_ready has no effect.
- **Head-of-line blocking**: if the head's destination stalls, later entries to other destinations wait. Delivery is strictly FIFO order.
- **Ready stability**: a ready asserted on a non-addressed port is ignored and causes no dequeue.
- **Mid-operation reset**: the FIFO flushes and any held entries are discarded. The upstream arbiter's lastGrant is unaffected by this block.
- **DEPTH=1**: io_enq_ready toggles, giving at most one message every 2 cycles.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release → io_enq_ready=1, io_count=0, all io_out_k_valid=0.
- Single message: enqueue src=1, dst=2, xact=3, chosen=1; io_out_2_ready=1 → io_out_2_valid=1 exactly one cycle later with src=1, xact=3, io_head_chosen=1; other valids stay 0; io_count returns to 0.
- Fill and full with DEPTH=2, all outputs not ready: enqueue dst=0 then dst=3 → io_count=2 and io_enq_ready=0. Assert io_out_0_ready for one cycle → io_out_3_valid next; io_enq_ready=1 one cycle after the dequeue.
- Head-of-line blocking: queue dst=1 then dst=0; hold io_out_1_ready=0 and io_out_0_ready=1 → io_out_0_valid stays 0 and io_count stays 2 until io_out_1_ready=1.
- Streaming with DEPTH=3 and wrap: send 10 back-to-back messages with dst cycling 0..3 and all ready=1 → 10 outputs in order with xact ids matching; io_count never exceeds 1; pointers wrap 3 times with no loss or duplication.
- Reset mid-operation: with io_count=2, drive reset=0 for one edge → io_count=0 and all valids 0 next cycle; the previously queued messages never appear.
